// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead block.
package cla_pkg;

    localparam int GROUP = 4;

    function automatic int ngroups(input int width);
        return width / GROUP;
    endfunction

    function automatic bit width_ok(input int width);
        return width inside {4, 8, 12, 16};
    endfunction

endpackage

// File: rtl/cla_carry_pipe_if.sv
// Upstream p/g/cin channel and downstream carry bundle of cla_carry_pipe.
// Handshake: a beat moves when valid & ready on the same rising edge; a producer
// holding valid keeps its data stable until ready, and ready never depends on valid.
interface cla_carry_pipe_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] p_q;
    logic             cout;
    logic             grp_p;
    logic             grp_g;
    logic             ovf;

    modport master (
        output in_valid, p, g, cin, out_ready,
        input  in_ready, out_valid, carry, p_q, cout, grp_p, grp_g, ovf
    );

    modport slave (
        input  in_valid, p, g, cin, out_ready,
        output in_ready, out_valid, carry, p_q, cout, grp_p, grp_g, ovf
    );
endinterface

// File: rtl/cla_group4.sv
// Four-bit lookahead cell: prefix generate/propagate, group G/P and carries from c_in.
module cla_group4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       c_in,
    output logic [3:0] lg,
    output logic [3:0] lp,
    output logic       gg,
    output logic       gp,
    output logic [3:0] carries
);
    // Prefixes are written out flat so every term is a single AND-OR level.
    assign lg[0] = g[0];
    assign lg[1] = g[1] | (p[1] & g[0]);
    assign lg[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
    assign lg[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    assign lp[0] = p[0];
    assign lp[1] = &p[1:0];
    assign lp[2] = &p[2:0];
    assign lp[3] = &p[3:0];

    assign gg = lg[3];
    assign gp = lp[3];

    assign carries[0] = c_in;
    assign carries[1] = lg[0] | (lp[0] & c_in);
    assign carries[2] = lg[1] | (lp[1] & c_in);
    assign carries[3] = lg[2] | (lp[2] & c_in);
endmodule

// File: rtl/cla_carry_pipe.sv
// Two-stage carry-lookahead carry generator: stage 1 registers per-group prefixes,
// stage 2 resolves group carry-ins and bit carries; p travels alongside for the sum stage.
module cla_carry_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    cla_carry_pipe_if.slave bus
);
    localparam int NG = ngroups(WIDTH);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("cla_carry_pipe: WIDTH %0d is not one of 4, 8, 12, 16", WIDTH);
    end

    logic             s1_valid, s2_valid, s1_en, s2_en;
    logic             s1_cin;
    logic [WIDTH-1:0] s1_p, s1_lg, s1_lp;
    logic [WIDTH-1:0] lg_d, lp_d;
    logic [NG-1:0]    s1_gg_unused, s1_gp_unused;
    logic [WIDTH-1:0] s1_c_unused;

    assign s2_en        = !s2_valid || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = s1_en;

    for (genvar k = 0; k < NG; k++) begin : g_s1_grp
        cla_group4 u_grp (
            .p       (bus.p[GROUP*k +: GROUP]),
            .g       (bus.g[GROUP*k +: GROUP]),
            .c_in    (1'b0),
            .lg      (lg_d[GROUP*k +: GROUP]),
            .lp      (lp_d[GROUP*k +: GROUP]),
            .gg      (s1_gg_unused[k]),
            .gp      (s1_gp_unused[k]),
            .carries (s1_c_unused[GROUP*k +: GROUP])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cin   <= 1'b0;
            s1_p     <= '0;
            s1_lg    <= '0;
            s1_lp    <= '0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_cin <= bus.cin;
                s1_p   <= bus.p;
                s1_lg  <= lg_d;
                s1_lp  <= lp_d;
            end
        end
    end

    // Group (G,P) pairs, zero-padded to four groups, reuse the same lookahead cell.
    logic [3:0] grp_gin, grp_pin, grp_lg, grp_lp, grp_c;
    logic       grp_gg_unused, grp_gp_unused, unused_bits;

    always_comb begin
        grp_gin = '0;
        grp_pin = '0;
        for (int k = 0; k < NG; k++) begin
            grp_gin[k] = s1_lg[GROUP*k + 3];
            grp_pin[k] = s1_lp[GROUP*k + 3];
        end
    end

    cla_group4 u_look (
        .p       (grp_pin),
        .g       (grp_gin),
        .c_in    (s1_cin),
        .lg      (grp_lg),
        .lp      (grp_lp),
        .gg      (grp_gg_unused),
        .gp      (grp_gp_unused),
        .carries (grp_c)
    );

    assign unused_bits = ^{grp_lg, grp_lp, grp_c};

    logic [WIDTH-1:0] carry_d;
    logic             cout_d, ovf_d;

    always_comb begin
        carry_d = '0;
        for (int k = 0; k < NG; k++) begin
            carry_d[GROUP*k] = grp_c[k];
            for (int i = 1; i < GROUP; i++) begin
                carry_d[GROUP*k + i] = s1_lg[GROUP*k + i - 1]
                                     | (s1_lp[GROUP*k + i - 1] & grp_c[k]);
            end
        end
    end

    assign cout_d = grp_lg[NG-1] | (grp_lp[NG-1] & s1_cin);
    assign ovf_d  = carry_d[WIDTH-1] ^ cout_d;

    logic [WIDTH-1:0] s2_carry, s2_p;
    logic             s2_cout, s2_grp_p, s2_grp_g, s2_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_carry <= '0;
            s2_p     <= '0;
            s2_cout  <= 1'b0;
            s2_grp_p <= 1'b0;
            s2_grp_g <= 1'b0;
            s2_ovf   <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_carry <= carry_d;
                s2_p     <= s1_p;
                s2_cout  <= cout_d;
                s2_grp_p <= grp_lp[NG-1];
                s2_grp_g <= grp_lg[NG-1];
                s2_ovf   <= ovf_d;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.carry     = s2_carry;
    assign bus.p_q       = s2_p;
    assign bus.cout      = s2_cout;
    assign bus.grp_p     = s2_grp_p;
    assign bus.grp_g     = s2_grp_g;
    assign bus.ovf       = s2_ovf;
endmodule
